// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the playback sequencer and its song_reader peer.
// Holds the sequencer state encoding and the song select width.
package song_sequencer_pkg;

  localparam int SEQ_SWIDTH     = 2;
  localparam int SONG_SEL_WIDTH = 2;

  typedef enum logic [SEQ_SWIDTH-1:0] {
    SEQ_IDLE    = 2'd0,
    SEQ_PLAYING = 2'd1,
    SEQ_PAUSED  = 2'd2,
    SEQ_FLUSH   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/song_sequencer_flush_timer.sv
// Loadable down-counter that times the reader flush window.
//   clk, rst_n : clock, async active-low clear
//   start      : load counter with length
//   length     : number of flush cycles (1..15)
//   active     : counter non-zero (a flush cycle is in progress)
//   last       : counter == 1 (final flush cycle)
module song_sequencer_flush_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] length,
  output logic       active,
  output logic       last
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start)             cnt_d = length;
    else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end

  assign active = (cnt_q != 4'd0);
  assign last   = (cnt_q == 4'd1);

endmodule

// File: rtl/song_sequencer.sv
// Playback controller: turns play/next button pulses and song_done into
// song_reader controls (play, song select, reader reset pulse).
//   clk, reset   : clock, async active-low reset
//   play_button  : pulse, toggles play/pause
//   next_button  : pulse, skip to next song
//   repeat_mode  : level, restart the current song when it finishes
//   song_done    : pulse from song_reader at end of song
//   play         : play enable to reader
//   song         : song select to reader
//   reader_reset : sync active-high reset to reader during a flush
//   flushing     : status, high while flushing
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int NUM_SONGS    = 4,
  parameter int FLUSH_CYCLES = 2,
  localparam int SW = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          play_button,
  input  logic          next_button,
  input  logic          repeat_mode,
  input  logic          song_done,
  output logic          play,
  output logic [SW-1:0] song,
  output logic          reader_reset,
  output logic          flushing
);

  localparam logic [SW-1:0] LAST_SONG = SW'(NUM_SONGS - 1);
  localparam logic [3:0]    FLUSH_LEN = 4'(FLUSH_CYCLES);

  seq_state_e    state_q, state_d, resume_q, resume_d;
  logic [SW-1:0] song_q, song_d, song_inc;
  logic          play_q, play_d, rr_q, rr_d, flushing_q, flushing_d;
  logic          flush_start, flush_active, flush_last;

  // Explicit compare keeps the wrap correct for non-power-of-2 song counts.
  assign song_inc = (song_q == LAST_SONG) ? '0 : song_q + SW'(1);

  song_sequencer_flush_timer u_flush_timer (
    .clk    (clk),
    .rst_n  (reset),
    .start  (flush_start),
    .length (FLUSH_LEN),
    .active (flush_active),
    .last   (flush_last)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SEQ_IDLE;
      resume_q   <= SEQ_IDLE;
      song_q     <= '0;
      play_q     <= 1'b0;
      rr_q       <= 1'b0;
      flushing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      song_q     <= song_d;
      play_q     <= play_d;
      rr_q       <= rr_d;
      flushing_q <= flushing_d;
    end
  end

  // Next state / next song. Song changes on the edge FLUSH is entered so it
  // is already stable while the reader sits in reset.
  always_comb begin
    state_d     = state_q;
    resume_d    = resume_q;
    song_d      = song_q;
    flush_start = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (next_button) begin
          song_d = song_inc; state_d = SEQ_FLUSH; resume_d = SEQ_IDLE; flush_start = 1'b1;
        end else if (play_button) begin
          state_d = SEQ_FLUSH; resume_d = SEQ_PLAYING; flush_start = 1'b1;
        end
      end
      SEQ_PLAYING: begin
        if (next_button) begin
          song_d = song_inc; state_d = SEQ_FLUSH; resume_d = SEQ_PLAYING; flush_start = 1'b1;
        end else if (song_done) begin
          state_d = SEQ_FLUSH; flush_start = 1'b1; resume_d = SEQ_PLAYING;
          if (!repeat_mode) begin
            song_d = song_inc;
            // Running off the end of the last song stops playback.
            if (song_q == LAST_SONG) resume_d = SEQ_IDLE;
          end
        end else if (play_button) begin
          state_d = SEQ_PAUSED;
        end
      end
      SEQ_PAUSED: begin
        if (next_button) begin
          song_d = song_inc; state_d = SEQ_FLUSH; resume_d = SEQ_PAUSED; flush_start = 1'b1;
        end else if (play_button) begin
          state_d = SEQ_PLAYING;
        end
      end
      SEQ_FLUSH: begin
        // Inputs are dropped here; leave on the last timed cycle (or if the
        // timer is somehow idle, so the FSM can never stick in FLUSH).
        if (flush_last || !flush_active) state_d = resume_q;
      end
      default: begin
        state_d  = SEQ_IDLE;
        resume_d = SEQ_IDLE;
        song_d   = '0;
      end
    endcase
  end

  // Registered outputs decoded from the upcoming state
  always_comb begin
    play_d     = (state_d == SEQ_PLAYING);
    rr_d       = (state_d == SEQ_FLUSH);
    flushing_d = (state_d == SEQ_FLUSH);
  end

  assign play         = play_q;
  assign song         = song_q;
  assign reader_reset = rr_q;
  assign flushing     = flushing_q;

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_button, next_button, repeat_mode, song_done;
  logic       play, reader_reset, flushing;
  logic [1:0] song;
  int errors = 0;
  int checks = 0;

  song_sequencer #(.NUM_SONGS(4), .FLUSH_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .play_button  (play_button),
    .next_button  (next_button),
    .repeat_mode  (repeat_mode),
    .song_done    (song_done),
    .play         (play),
    .song         (song),
    .reader_reset (reader_reset),
    .flushing     (flushing)
  );

  always #5 clk = ~clk;

  // Drive one-cycle pulses from a negedge; return at the next negedge,
  // when the outputs reflect the edge that sampled them.
  task automatic drive(input logic n, input logic p, input logic d);
    next_button = n; play_button = p; song_done = d;
    @(negedge clk);
    next_button = 0; play_button = 0; song_done = 0;
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; play_button = 0; next_button = 0; repeat_mode = 0; song_done = 0;
    cycles(2);
    checks++; if ({play, song, reader_reset, flushing} !== 5'b0) begin errors++; $display("FAIL reset_hold got=%b exp=00000", {play, song, reader_reset, flushing}); end
    reset = 1'b1;
    cycles(2);
    checks++; if ({play, song, reader_reset, flushing} !== 5'b0) begin errors++; $display("FAIL reset_idle got=%b exp=00000", {play, song, reader_reset, flushing}); end
  endtask

  task automatic test_play_from_idle;
    drive(0, 1, 0);
    checks++; if ({play, song, reader_reset, flushing} !== 5'b0_00_1_1) begin errors++; $display("FAIL play_flush1 got=%b exp=00011", {play, song, reader_reset, flushing}); end
    cycles(1);
    checks++; if ({play, song, reader_reset, flushing} !== 5'b0_00_1_1) begin errors++; $display("FAIL play_flush2 got=%b exp=00011", {play, song, reader_reset, flushing}); end
    cycles(1);
    checks++; if ({play, song, reader_reset, flushing} !== 5'b1_00_0_0) begin errors++; $display("FAIL play_start got=%b exp=10000", {play, song, reader_reset, flushing}); end
  endtask

  task automatic test_next;
    drive(1, 0, 0);
    checks++; if ({play, song, flushing} !== 4'b0_01_1) begin errors++; $display("FAIL next_flush got=%b exp=0011", {play, song, flushing}); end
    cycles(2);
    checks++; if ({play, song, reader_reset} !== 4'b1_01_0) begin errors++; $display("FAIL next_resume got=%b exp=1010", {play, song, reader_reset}); end
  endtask

  task automatic test_pause;
    drive(0, 1, 0);
    checks++; if ({play, song, reader_reset, flushing} !== 5'b0_01_0_0) begin errors++; $display("FAIL pause got=%b exp=00100", {play, song, reader_reset, flushing}); end
    drive(0, 0, 1);
    checks++; if ({play, song, reader_reset} !== 4'b0_01_0) begin errors++; $display("FAIL paused_done_ignored got=%b exp=0010", {play, song, reader_reset}); end
    drive(0, 1, 0);
    checks++; if ({play, song, reader_reset, flushing} !== 5'b1_01_0_0) begin errors++; $display("FAIL unpause got=%b exp=10100", {play, song, reader_reset, flushing}); end
  endtask

  task automatic test_same_cycle;
    drive(1, 1, 1);
    checks++; if ({song, flushing} !== 3'b10_1) begin errors++; $display("FAIL same_cycle_song got=%b exp=101", {song, flushing}); end
    cycles(2);
    checks++; if ({play, song, flushing} !== 4'b1_10_0) begin errors++; $display("FAIL same_cycle_resume got=%b exp=1100", {play, song, flushing}); end
  endtask

  task automatic test_last_song;
    drive(1, 0, 0); cycles(2);
    checks++; if ({play, song} !== 3'b1_11) begin errors++; $display("FAIL last_setup got=%b exp=111", {play, song}); end
    repeat_mode = 0;
    drive(0, 0, 1);
    checks++; if ({play, song, reader_reset} !== 4'b0_00_1) begin errors++; $display("FAIL last_wrap got=%b exp=0001", {play, song, reader_reset}); end
    cycles(2);
    checks++; if ({play, song, reader_reset, flushing} !== 5'b0) begin errors++; $display("FAIL last_idle got=%b exp=00000", {play, song, reader_reset, flushing}); end
    cycles(3);
    checks++; if ({play, flushing} !== 2'b00) begin errors++; $display("FAIL last_stays_idle got=%b exp=00", {play, flushing}); end
  endtask

  task automatic test_repeat;
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0); cycles(2); end
    checks++; if ({play, song} !== 3'b0_11) begin errors++; $display("FAIL idle_next3 got=%b exp=011", {play, song}); end
    drive(0, 1, 0); cycles(2);
    repeat_mode = 1;
    drive(0, 0, 1);
    checks++; if ({play, song, reader_reset} !== 4'b0_11_1) begin errors++; $display("FAIL repeat_flush got=%b exp=0111", {play, song, reader_reset}); end
    cycles(2);
    checks++; if ({play, song, reader_reset} !== 4'b1_11_0) begin errors++; $display("FAIL repeat_resume got=%b exp=1110", {play, song, reader_reset}); end
    repeat_mode = 0;
  endtask

  task automatic test_flush_drop;
    drive(1, 0, 0);
    drive(1, 1, 0);
    checks++; if ({play, song, flushing} !== 4'b0_00_1) begin errors++; $display("FAIL drop_flush2 got=%b exp=0001", {play, song, flushing}); end
    cycles(1);
    checks++; if ({play, song, flushing} !== 4'b1_00_0) begin errors++; $display("FAIL drop_resume got=%b exp=1000", {play, song, flushing}); end
  endtask

  task automatic test_reset_mid_flush;
    drive(1, 0, 0);
    checks++; if ({song, flushing} !== 3'b01_1) begin errors++; $display("FAIL midrst_setup got=%b exp=011", {song, flushing}); end
    reset = 1'b0;
    #1;
    checks++; if ({play, song, reader_reset, flushing} !== 5'b0) begin errors++; $display("FAIL midrst_async got=%b exp=00000", {play, song, reader_reset, flushing}); end
    @(negedge clk); reset = 1'b1;
    cycles(1);
    drive(1, 0, 0);
    checks++; if ({play, song, flushing} !== 4'b0_01_1) begin errors++; $display("FAIL midrst_idle_next got=%b exp=0011", {play, song, flushing}); end
    cycles(2);
    checks++; if ({play, song, flushing} !== 4'b0_01_0) begin errors++; $display("FAIL midrst_idle got=%b exp=0010", {play, song, flushing}); end
  endtask

  initial begin
    test_reset;
    test_play_from_idle;
    test_next;
    test_pause;
    test_same_cycle;
    test_last_song;
    test_repeat;
    test_flush_drop;
    test_reset_mid_flush;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
